// File: rtl/stage_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : stage_sequencer_if
// Brief    : Control/status bundle between the stage sequencer and the core.
// Revision : 1.0
// ============================================================================
interface stage_sequencer_if #(
    parameter int CNT_W = 32
);
    logic             start;
    logic             halt_req;
    logic             dec_is_mem;
    logic             dec_is_in;
    logic             dec_is_out;
    logic             in_busy;
    logic             out_busy;
    logic             fetch_en;
    logic             decode_en;
    logic             execute_en;
    logic             mem_en;
    logic             wb_en;
    logic [2:0]       state;
    logic             busy;
    logic [CNT_W-1:0] retired;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output start, halt_req, dec_is_mem, dec_is_in, dec_is_out, in_busy, out_busy,
        input  fetch_en, decode_en, execute_en, mem_en, wb_en, state, busy,
               retired, stall_cycles
    );

    modport slave (
        input  start, halt_req, dec_is_mem, dec_is_in, dec_is_out, in_busy, out_busy,
        output fetch_en, decode_en, execute_en, mem_en, wb_en, state, busy,
               retired, stall_cycles
    );
endinterface
`default_nettype wire

// File: rtl/stage_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : stage_sequencer
// Brief    : Per-stage enable sequencer for the multi-cycle core with fetch/mem
//            latency waits, I/O stalls, halt control and performance counters.
// Revision : 1.0
// ============================================================================
module stage_sequencer #(
    parameter int FETCH_LAT = 1,
    parameter int MEM_LAT   = 1,
    parameter bit SKIP_MEM  = 1'b0,
    parameter int CNT_W     = 32
) (
    input  wire logic        clk,
    input  wire logic        rstn,
    stage_sequencer_if.slave bus
);
    localparam int c_LAT_MAX = (FETCH_LAT > MEM_LAT) ? FETCH_LAT : MEM_LAT;
    localparam int c_LAT_W   = $clog2(c_LAT_MAX + 1);
    localparam logic [c_LAT_W-1:0] c_FETCH_LAST = c_LAT_W'(FETCH_LAT - 1);
    localparam logic [c_LAT_W-1:0] c_MEM_LAST   = c_LAT_W'(MEM_LAT - 1);
    localparam logic [CNT_W-1:0]   c_CNT_MAX    = '1;

    typedef enum logic [2:0] {
        c_IDLE   = 3'd0,
        c_WAIT   = 3'd1,
        c_FETCH  = 3'd2,
        c_DECODE = 3'd3,
        c_EXEC   = 3'd4,
        c_MEM    = 3'd5,
        c_WB     = 3'd6,
        c_HALT   = 3'd7
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [c_LAT_W-1:0] r_lat;
    logic               r_fetch_en;
    logic               r_decode_en;
    logic               r_mem_en;
    logic               r_wb_en;
    logic               r_busy;
    logic [CNT_W-1:0]   r_retired;
    logic [CNT_W-1:0]   r_stall_cycles;
    logic               w_stall;

    always_comb begin
        w_stall = (bus.dec_is_in & bus.in_busy) | (bus.dec_is_out & bus.out_busy);
        w_next  = r_state;
        case (r_state)
            c_IDLE:   if (bus.start) w_next = c_WAIT;
            c_WAIT:   if (r_lat == c_FETCH_LAST) w_next = c_FETCH;
            c_FETCH:  w_next = c_DECODE;
            c_DECODE: w_next = c_EXEC;
            c_EXEC: begin
                if (!w_stall) begin
                    w_next = (SKIP_MEM && !bus.dec_is_mem) ? c_WB : c_MEM;
                end
            end
            c_MEM:    if (r_lat == c_MEM_LAST) w_next = c_WB;
            c_WB:     w_next = bus.halt_req ? c_HALT : c_WAIT;
            c_HALT:   if (!bus.start) w_next = c_IDLE;
            default:  w_next = c_IDLE;
        endcase
    end

    // Strobes are registered from the next state so each is high exactly in its state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state        <= c_IDLE;
            r_lat          <= '0;
            r_fetch_en     <= 1'b0;
            r_decode_en    <= 1'b0;
            r_mem_en       <= 1'b0;
            r_wb_en        <= 1'b0;
            r_busy         <= 1'b0;
            r_retired      <= '0;
            r_stall_cycles <= '0;
        end else begin
            r_state     <= w_next;
            r_lat       <= (w_next == r_state) ? r_lat + 1'b1 : '0;
            r_fetch_en  <= (w_next == c_FETCH);
            r_decode_en <= (w_next == c_DECODE);
            r_mem_en    <= (w_next == c_MEM) && (r_state != c_MEM);
            r_wb_en     <= (w_next == c_WB);
            r_busy      <= (w_next != c_IDLE) && (w_next != c_HALT);
            if (r_state == c_WB) begin
                r_retired <= r_retired + 1'b1;
            end
            if ((r_state == c_EXEC) && w_stall && (r_stall_cycles != c_CNT_MAX)) begin
                r_stall_cycles <= r_stall_cycles + 1'b1;
            end
        end
    end

    assign bus.fetch_en     = r_fetch_en;
    assign bus.decode_en    = r_decode_en;
    assign bus.execute_en   = (r_state == c_EXEC) && !w_stall;
    assign bus.mem_en       = r_mem_en;
    assign bus.wb_en        = r_wb_en;
    assign bus.state        = r_state;
    assign bus.busy         = r_busy;
    assign bus.retired      = r_retired;
    assign bus.stall_cycles = r_stall_cycles;
endmodule
`default_nettype wire

// File: doc/stage_sequencer.md
# stage_sequencer

Parametrised control sequencer for the multi-cycle core. It generates the per-stage enable strobes (fetch, decode, execute, memory, write-back) that the datapath uses to load its FD/DE/EM/MW registers, waiting for BRAM latency and stalling on I/O busy. Beyond a fixed single-wait ring, it has configurable fetch and memory latency, an optional memory-stage bypass for non-memory instructions, halt/restart control, and retired-instruction and stall-cycle counters.

## Interface
- FETCH_LAT, 1, cycles in WAIT before the instruction word is valid (must be ≥1)
- MEM_LAT, 1, cycles spent in MEM per memory-stage visit (must be ≥1)
- SKIP_MEM, 0, 1 = instructions with dec_is_mem=0 go EXEC→WB directly
- CNT_W, 32, width of the performance counters
- clk  in  1  clock; all state changes on posedge
- rstn  in  1  asynchronous, active-low reset
- start  in  1  level; leaves IDLE when high
- halt_req  in  1  sampled in WB; enter HALT instead of WAIT
- dec_is_mem  in  1  current instruction uses the memory stage (valid from EXEC on)
- dec_is_in  in  1  current instruction is an input instruction
- dec_is_out  in  1  current instruction is an output instruction
- in_busy  in  1  input channel not ready
- out_busy  in  1  output channel not ready
- fetch_en  out  1  capture instruction word into FD
- decode_en  out  1  load DE registers
- execute_en  out  1  load EM registers / issue mem & I/O request
- mem_en  out  1  first cycle of MEM
- wb_en  out  1  commit PC and register writes
- state  out  3  current state code
- busy  out  1  high in every state except IDLE and HALT
- retired  out  CNT_W  count of completed WB cycles
- stall_cycles  out  CNT_W  count of EXEC cycles held by I/O busy

## Operation
- State codes: IDLE=0, WAIT=1, FETCH=2, DECODE=3, EXEC=4, MEM=5, WB=6, HALT=7.
- IDLE: start=1 → WAIT; else stay.
- WAIT: latency counter loaded 0 on entry, increments each cycle; after FETCH_LAT cycles → FETCH.
- FETCH: fetch_en=1 for one cycle → DECODE.
- DECODE: decode_en=1 for one cycle → EXEC.
- EXEC: stall = (dec_is_in & in_busy) | (dec_is_out & out_busy). If stall, remain in EXEC with execute_en=0 and stall_cycles +1. Otherwise execute_en=1 this cycle, then → MEM, or → WB when SKIP_MEM=1 and dec_is_mem=0.
- MEM: counter from 0; mem_en=1 on first MEM cycle only; after MEM_LAT cycles → WB.
- WB: wb_en=1 for one cycle, retired +1; halt_req=1 → HALT, else → WAIT.
- HALT: strobes 0; start=0 → IDLE (start must drop and rise again to restart).
- Strobes are mutually exclusive; at most one is high per cycle.
- Strobes other than execute_en are decoded from state/counter only. execute_en is combinational from EXEC plus the busy/decoded inputs.
- retired wraps modulo 2^CNT_W. stall_cycles saturates at all-ones.
- Unused state codes never occur.

## Timing
- Reset (rstn=0, asynchronous): state=IDLE. All strobes, busy, retired and stall_cycles are 0 immediately, without waiting for a clock edge. This holds when asserted mid-instruction; the instruction is abandoned without wb_en. Release is synchronous to the next posedge.
- Per-instruction latency with no stalls, WB-cycle to next WB-cycle: FETCH_LAT+3+MEM_LAT+1. Memory-bypass instructions (SKIP_MEM=1, dec_is_mem=0) take FETCH_LAT+4.
- From IDLE with start=1: first fetch_en occurs FETCH_LAT+1 cycles after the start-sampling edge.
- Busy changes during a stall are honoured on the same cycle. If busy drops at cycle n, execute_en=1 in cycle n.
- halt_req outside WB is ignored.
- Simultaneous halt_req and start in WB: HALT wins.

## Test plan
- Defaults, start=1, dec_is_mem=0, no busy → WB every 6 cycles; 10 instructions → retired=10, stall_cycles=0.
- FETCH_LAT=3, MEM_LAT=2, SKIP_MEM=0 → fetch_en 4 cycles after WAIT entry; WB-to-WB period 9; mem_en one cycle per instruction.
- SKIP_MEM=1, alternating dec_is_mem 1/0 → periods 6/5 alternate; mem_en only for the mem instructions.
- dec_is_out=1, out_busy=1 for 5 cycles in EXEC → execute_en=0 for those 5 cycles, stall_cycles=5; execute_en=1 in the cycle out_busy falls. dec_is_in=1 with out_busy=1 → no stall.
- halt_req=1 in WB → HALT, busy=0; start held high stays in HALT. start 0 → IDLE; start 1 → resumes WAIT.
- rstn pulsed low during MEM → outputs 0 immediately, no wb_en, retired=0. CNT_W=4 with 17 instructions → retired=1. Forced 20 stall cycles → stall_cycles=15.
